multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle FETCH/DECODE/EXEC/MEM/WB control FSM.
// Define CTRL_PERF_EN to build the retired-instruction counter.
module multicycle_ctrl #(
    parameter int ALUOP_W  = 3,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         op,
    input  logic               zero,
    input  logic               imem_ack,
    input  logic               dmem_ack,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         PCsrc,
    output logic               m2reg,
    output logic               wmem,
    output logic               memc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               alucsrc,
    output logic               wreg,
    output logic               jal,
    output logic               fault,
    output logic [2:0]         state,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam int WCNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [WCNT_W-1:0] WLAST =
        WCNT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

    state_t            st, nxt;
    logic [WCNT_W-1:0] wcnt;
    logic              tmo;
    logic [3:0]        opq;
    logic [2:0]        aluop_q;

    logic              d_m2reg, d_memc, d_alucsrc, d_jal;
    logic [2:0]        d_aluop;

    logic              is_branch, is_mem, is_store, is_jal, is_jalr;

    assign is_branch = (opq[3:1] == 3'b001);
    assign is_mem    = (opq[3:2] == 2'b01);
    assign is_store  = is_mem & opq[1];
    assign is_jal    = (opq == 4'h0);
    assign is_jalr   = (opq == 4'h1);

    // Timeout fires on the wait cycle in which the counter would reach WAIT_MAX.
    assign tmo = (WAIT_MAX > 0) && (wcnt == WLAST);

    assign state = st;
    assign ALUOp = ALUOP_W'(aluop_q);

    always_comb begin
        d_m2reg   = 1'b0;
        d_memc    = 1'b0;
        d_alucsrc = 1'b0;
        d_jal     = 1'b0;
        d_aluop   = 3'd0;
        case (op)
            4'h0: d_jal = 1'b1;
            4'h1: begin d_jal = 1'b1; d_alucsrc = 1'b1; end
            4'h2: d_aluop = 3'd4;
            4'h3: d_aluop = 3'd5;
            4'h4: begin d_m2reg = 1'b1; d_alucsrc = 1'b1; end
            4'h5: begin d_m2reg = 1'b1; d_memc = 1'b1; d_alucsrc = 1'b1; end
            4'h6: d_alucsrc = 1'b1;
            4'h7: begin d_memc = 1'b1; d_alucsrc = 1'b1; end
            4'h8: d_aluop = 3'd0;
            4'h9: d_aluop = 3'd1;
            4'hA: d_aluop = 3'd2;
            4'hB: d_aluop = 3'd3;
            4'hC: begin d_aluop = 3'd0; d_alucsrc = 1'b1; end
            4'hD: begin d_aluop = 3'd1; d_alucsrc = 1'b1; end
            4'hE: begin d_aluop = 3'd2; d_alucsrc = 1'b1; end
            4'hF: begin d_aluop = 3'd3; d_alucsrc = 1'b1; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= S_FETCH;
        end else begin
            st <= nxt;
        end
    end

    always_comb begin
        nxt      = st;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        PCsrc    = 2'd0;
        wmem     = 1'b0;
        wreg     = 1'b0;
        fault    = 1'b0;
        // Outputs are held quiet while reset is asserted.
        if (!rst) begin
            unique case (st)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_we = 1'b1;
                        nxt   = S_DECODE;
                    end else if (tmo) begin
                        nxt = S_FAULT;
                    end
                end
                S_DECODE: nxt = S_EXEC;
                S_EXEC: begin
                    if (is_branch) begin
                        pc_we = 1'b1;
                        PCsrc = zero ? 2'd1 : 2'd0;
                        nxt   = S_FETCH;
                    end else if (is_mem) begin
                        nxt = S_MEM;
                    end else begin
                        nxt = S_WB;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    wmem     = is_store;
                    if (dmem_ack) begin
                        if (is_store) begin
                            pc_we = 1'b1;
                            nxt   = S_FETCH;
                        end else begin
                            nxt = S_WB;
                        end
                    end else if (tmo) begin
                        nxt = S_FAULT;
                    end
                end
                S_WB: begin
                    wreg  = 1'b1;
                    pc_we = 1'b1;
                    PCsrc = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
                    nxt   = S_FETCH;
                end
                S_FAULT: fault = 1'b1;
                default: nxt = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt <= '0;
        end else if (WAIT_MAX == 0) begin
            wcnt <= '0;
        end else if ((st == S_FETCH && !imem_ack) ||
                     (st == S_MEM && !dmem_ack)) begin
            wcnt <= wcnt + 1'b1;
        end else begin
            wcnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opq     <= 4'h0;
            m2reg   <= 1'b0;
            memc    <= 1'b0;
            alucsrc <= 1'b0;
            jal     <= 1'b0;
            aluop_q <= 3'd0;
        end else if (st == S_DECODE) begin
            opq     <= op;
            m2reg   <= d_m2reg;
            memc    <= d_memc;
            alucsrc <= d_alucsrc;
            jal     <= d_jal;
            aluop_q <= d_aluop;
        end
    end

`ifdef CTRL_PERF_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (pc_we) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign retired = cnt_q;
`else
    assign retired = '0;
`endif

endmodule
